// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with frame-aligned value updates.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] value_in,
    input  logic        load,
    output logic        ready,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    typedef enum logic {OFF = 1'b0, SCAN = 1'b1} state_t;

    state_t        state, state_n;
    logic [1:0]    dig, dig_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   disp, disp_n;
    logic [15:0]   pend, pend_n;
    logic          disp_v, disp_v_n;
    logic          pend_v, pend_v_n;
    logic [3:0]    an_n;
    logic [7:0]    seg_n;
    logic          frame_done_n;
    logic          accept;
    logic          boundary;
    logic [3:0]    nib;
    logic          lz_blank;

    function automatic logic [7:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_seg = 8'hC0;  4'h1: hex_seg = 8'hF9;
            4'h2: hex_seg = 8'hA4;  4'h3: hex_seg = 8'hB0;
            4'h4: hex_seg = 8'h99;  4'h5: hex_seg = 8'h92;
            4'h6: hex_seg = 8'h82;  4'h7: hex_seg = 8'hF8;
            4'h8: hex_seg = 8'h80;  4'h9: hex_seg = 8'h90;
            4'hA: hex_seg = 8'h88;  4'hB: hex_seg = 8'h83;
            4'hC: hex_seg = 8'hC6;  4'hD: hex_seg = 8'hA1;
            4'hE: hex_seg = 8'h86;  default: hex_seg = 8'h8E;
        endcase
    endfunction

    // Handshake: ready is high while the single pending slot is empty; a load is
    // taken on any clock edge where load && ready, otherwise the source must hold it.
    assign ready    = !pend_v;
    assign accept   = load && !pend_v;
    assign boundary = (state == SCAN) && en && (dig == 2'd3) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= OFF;
            dig        <= 2'd0;
            cnt        <= '0;
            disp       <= 16'h0000;
            pend       <= 16'h0000;
            disp_v     <= 1'b0;
            pend_v     <= 1'b0;
            an         <= 4'hF;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            dig        <= dig_n;
            cnt        <= cnt_n;
            disp       <= disp_n;
            pend       <= pend_n;
            disp_v     <= disp_v_n;
            pend_v     <= pend_v_n;
            an         <= an_n;
            seg        <= seg_n;
            frame_done <= frame_done_n;
        end
    end

    always_comb begin
        state_n  = state;
        dig_n    = dig;
        cnt_n    = cnt;
        disp_n   = disp;
        pend_n   = pend;
        disp_v_n = disp_v;
        pend_v_n = pend_v;
        if (state == OFF) begin
            dig_n = 2'd0;
            cnt_n = '0;
            if (en && (accept || pend_v)) begin
                // Starting from OFF there is no frame to tear, so commit immediately.
                disp_n   = pend_v ? pend : value_in;
                disp_v_n = 1'b1;
                pend_v_n = 1'b0;
                state_n  = SCAN;
            end else if (en && disp_v) begin
                state_n = SCAN;
            end else if (accept) begin
                pend_n   = value_in;
                pend_v_n = 1'b1;
            end
        end else begin
            if (!en) begin
                state_n = OFF;
                dig_n   = 2'd0;
                cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
                cnt_n = '0;
                dig_n = dig + 2'd1;
                if (boundary && pend_v) begin
                    disp_n   = pend;
                    pend_v_n = 1'b0;
                end
            end else begin
                cnt_n = cnt + CW'(1);
            end
            // Same-edge loads only ever land in pend; pend_v was clear for accept.
            if (accept) begin
                pend_n   = value_in;
                pend_v_n = 1'b1;
            end
        end
    end

    always_comb begin
        case (dig)
            2'd0:    nib = disp[3:0];
            2'd1:    nib = disp[7:4];
            2'd2:    nib = disp[11:8];
            default: nib = disp[15:12];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        case (dig)
            2'd0:    lz_blank = 1'b0;
            2'd1:    lz_blank = (disp[15:4] == 12'h000);
            2'd2:    lz_blank = (disp[15:8] == 8'h00);
            default: lz_blank = (disp[15:12] == 4'h0);
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        an_n         = 4'hF;
        seg_n        = 8'hFF;
        frame_done_n = boundary;
        if ((state == SCAN) && (cnt >= CNT_BLANK) && !lz_blank) begin
            an_n  = ~(4'b0001 << dig);
            seg_n = hex_seg(nib);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios then random traffic, every cycle
// compared against a frame-position reference model.
module tb_seven_seg_scan_ctrl;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * RD;
    localparam logic [7:0] SEG_TBL [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic        load = 1'b0;
    logic        ready;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    int n_total = 0;
    int n_bad   = 0;

    // clock / reset block
    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .en(en), .value_in(value_in), .load(load),
        .ready(ready), .an(an), .seg(seg), .frame_done(frame_done));

    // reference model: position within the frame, committed value, pending queue
    bit          m_on;
    int          m_pos;
    logic [15:0] m_disp;
    bit          m_disp_v;
    logic [15:0] exp_q[$];
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
    logic        exp_fd;
    bit          last_accept;

    function automatic void model_reset();
        m_on = 0; m_pos = 0; m_disp = 16'h0; m_disp_v = 0;
        exp_q.delete();
        exp_an = 4'hF; exp_seg = 8'hFF; exp_fd = 1'b0;
    endfunction

    function automatic void model_edge();
        int          d;
        int          off;
        bit          lit;
        logic [15:0] upper;
        logic [3:0]  one_hot;
        exp_an  = 4'hF;
        exp_seg = 8'hFF;
        if (m_on) begin
            d     = m_pos / RD;
            off   = m_pos % RD;
            upper = m_disp >> (4 * d);
            lit   = (off >= BC);
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0 && upper == 16'h0) lit = 0;
`endif
            if (lit) begin
                one_hot = 4'b0001 << d;
                exp_an  = ~one_hot;
                exp_seg = SEG_TBL[upper[3:0]];
            end
        end
        exp_fd      = m_on && en && (m_pos == FRAME - 1);
        last_accept = load && (exp_q.size() == 0);
        if (!m_on) begin
            if (en && (last_accept || exp_q.size() > 0)) begin
                if (exp_q.size() > 0) m_disp = exp_q.pop_front();
                else m_disp = value_in;
                m_disp_v = 1; m_on = 1; m_pos = 0;
            end else if (en && m_disp_v) begin
                m_on = 1; m_pos = 0;
            end else if (last_accept) begin
                exp_q.push_back(value_in);
            end
        end else if (!en) begin
            m_on = 0; m_pos = 0;
            if (last_accept) exp_q.push_back(value_in);
        end else begin
            if (m_pos == FRAME - 1 && exp_q.size() > 0) m_disp = exp_q.pop_front();
            if (last_accept) exp_q.push_back(value_in);
            m_pos = (m_pos + 1) % FRAME;
        end
    endfunction

    // scoreboard compare
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // driver: called right after a negedge, returns at the next negedge
    task automatic step(input logic e, input logic l, input logic [15:0] v);
        en = e; load = l; value_in = v;
        model_edge();
        @(posedge clk);
        #1;
        chk("an", {12'h0, an}, {12'h0, exp_an});
        chk("seg", {8'h0, seg}, {8'h0, exp_seg});
        chk("frame_done", {15'h0, frame_done}, {15'h0, exp_fd});
        chk("ready", {15'h0, ready}, {15'h0, (exp_q.size() == 0)});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0);
    endtask

    task automatic do_load(input logic [15:0] v);
        int n = 0;
        do begin
            step(1'b1, 1'b1, v);
            n++;
        end while (!last_accept && n < 4 * FRAME);
        if (!last_accept) begin
            n_total++;
            n_bad++;
            $error("FAIL load_timeout value=%h cycles=%0d", v, n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_seg", {8'h0, seg}, 16'h00FF);
        chk("rst_frame_done", {15'h0, frame_done}, 16'h0000);
        chk("rst_ready", {15'h0, ready}, 16'h0001);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // first load, digit 0 lit after the blank window
        do_load(16'h12AF);
        idle(3);
        chk("first_digit_an", {12'h0, an}, 16'h000E);
        chk("first_digit_seg", {8'h0, seg}, 16'h008E);
        idle(70);

        // mid-frame update commits at the boundary
        do_load(16'h1234);
        idle(FRAME + 10);
        do_load(16'hBEEF);
        idle(FRAME + 10);

        // load exactly on the boundary edge, then a second load while not ready
        for (int i = 0; i < FRAME && !(m_on && m_pos == FRAME - 1); i++) idle(1);
        step(1'b1, 1'b1, 16'h5A3C);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'h7777);
        idle(2 * FRAME + 4);

        // drop enable mid-slot, then resume
        idle(11);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0);
        idle(FRAME + 6);

        // asynchronous reset with a value still pending
        do_load(16'h2222);
        idle(3);
        step(1'b1, 1'b1, 16'h3333);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_an", {12'h0, an}, 16'h000F);
        chk("async_rst_seg", {8'h0, seg}, 16'h00FF);
        chk("async_rst_ready", {15'h0, ready}, 16'h0001);
        model_reset();
        en = 1'b0; load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(20);

        // leading zeros and an all-zero value
        do_load(16'h0005);
        idle(FRAME + 4);
        do_load(16'h0000);
        idle(2 * FRAME + 4);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares the 4-digit common-anode seven-segment display between the four hex nibbles of a 16-bit value. It rotates the active anode at a fixed refresh rate and inserts anti-ghosting blank time. New values arrive through a load/ready handshake and are committed only at frame boundaries, so the display never tears. It sits between the ALU result path and the board display pins.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot; must be >= 2.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en  input  1  display enable
value_in  input  16  value to display; nibble k is shown on digit k
load  input  1  load request, qualified by ready
ready  output  1  high when the block can accept a load
an  output  4  anode enables, active-low; an[k] drives digit k
seg  output  8  segments, active-low; seg[7] is dp and is always 1
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: an=4'b1111, seg=8'hFF, frame_done=0, ready=1. Internal state: FSM=OFF, dig=0, cnt=0, disp=0, pend=0, pend_v=0, disp_v=0.
- Handshake:
  - ready = !pend_v.
  - A load is accepted on an edge where load && ready; value_in is captured into pend and pend_v is set.
  - load while ready=0 is ignored. The source must hold the request until it is accepted.
- FSM states:
  - OFF: cnt and dig are held at 0; outputs are blank.
    - If an accepted load or pend_v is present and en=1: disp<=value (pend, or value_in for a same-edge load), disp_v<=1, pend_v<=0, go to SCAN with dig=0, cnt=0.
    - If disp_v=1, en=1 and nothing is pending: go to SCAN.
  - SCAN:
    - cnt counts 0..REFRESH_DIV-1. At REFRESH_DIV-1: cnt<=0, dig<=dig+1 (mod 4).
    - en=0 at any edge: go to OFF, dig<=0, cnt<=0. disp is retained.
- Frame boundary: SCAN, dig==3, cnt==REFRESH_DIV-1. On that edge:
  - frame_done<=1 for exactly one cycle.
  - If pend_v: disp<=pend, pend_v<=0, so ready rises on the next cycle.
  - A load accepted on the same edge goes to pend only. It displays at the next boundary, never the current one.
- Outputs are registered and reflect the (state, dig, cnt, disp) of the previous cycle (1-cycle latency).
  - In OFF, or when cnt < BLANK_CYCLES: an=1111, seg=FF.
  - Otherwise: an = one-hot-low of dig, and seg = decode of disp[4*dig+3:4*dig].
- Decode, hex digit to seg: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Width rules:
  - cnt width is clog2(REFRESH_DIV); dig is 2 bits and wraps 3 to 0.
  - No other arithmetic.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge. Pending data is discarded.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: for dig in 3..1, the slot is blanked (an=1111, seg=FF) when that nibble and all higher nibbles of disp are zero. Digit 0 is always shown. Slot timing and frame_done are unchanged.
- Undefined: all four digits are always shown, including leading zeros.

Test Plan:
Use REFRESH_DIV=8 and BLANK_CYCLES=2 for all scenarios.
1. Reset, then load value_in=16'h12AF with en=1:
   - Entering SCAN: digit 0 blank for 2 cycles, then an=1110, seg=8E for 6 cycles.
   - Then an=1101/seg=88, an=1011/seg=A4, an=0111/seg=F9, each slot 8 cycles.
   - frame_done pulses once per 32 cycles.
2. While showing 16'h1234, load 16'hBEEF mid-frame:
   - ready drops the next cycle.
   - Digits keep showing 1234 until frame_done, then BEEF.
   - ready=1 one cycle after the boundary.
3. Assert load at the exact boundary edge with pend_v=0:
   - The value shows one full frame later.
   - A second load while ready=0 is ignored; the first value is shown.
4. Drop en mid-slot:
   - an=1111 one cycle later.
   - Raise en: scan restarts at digit 0, cnt 0, with disp unchanged.
5. Assert rst asynchronously mid-slot:
   - an=1111, seg=FF, ready=1 before the next clk edge.
   - Display stays off until a new load.
6. With LEADING_ZERO_BLANK_EN defined, load 16'h0005:
   - Only digit 0 is lit (an=1110, seg=92).
   - Slots 1-3 show an=1111; frame period is still 32 cycles.
   - Load 16'h0000: digit 0 shows C0.
